wave_capture: RTL and testbench

- Upstream producer for the waveform display stage.
- Takes the audio sample stream, applies decimation, and arms on a positive zero crossing with hysteresis. A timeout forces a trigger if no crossing arrives.
- Writes 256 offset-binary 8-bit samples into the half of the dual-half 512-entry sample RAM that the display is not reading.
- Flips `read_index` once the display reports it is idle, so display and capture swap halves.

---
 rtl/wave_capture.sv | 146 ++++++++++++++
 tb/tb_wave_capture.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wave_capture.sv
// Capture stage feeding the waveform display: decimates the audio stream, arms on a
// positive zero crossing with hysteresis (or a timeout) and fills the idle RAM half.
module wave_capture #(
   parameter int DECIM   = 1,
   parameter int HYST    = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        new_sample_ready,
   input  logic [15:0] new_sample_in,
   input  logic        wave_display_idle,
   output logic [8:0]  write_address,
   output logic        write_enable,
   output logic [7:0]  write_sample,
   output logic        read_index,
   output logic [1:0]  capture_state
);

   typedef enum logic [1:0] {
      ST_ARMED  = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   localparam logic [7:0]         DECIM_LAST   = 8'(DECIM - 1);
   localparam logic [15:0]        TIMEOUT_LAST = 16'(TIMEOUT - 1);
   localparam logic signed [15:0] HYST_NEG     = 16'(-HYST);

   state_t      state_q, state_d;
   logic [7:0]  decimCnt_q, decimCnt_d;
   logic [15:0] timeoutCnt_q, timeoutCnt_d;
   logic [7:0]  index_q, index_d;
   logic        lowSeen_q, lowSeen_d;
   logic        readIndex_q, readIndex_d;
   logic        writeEn_q, writeEn_d;
   logic [8:0]  writeAddr_q, writeAddr_d;
   logic [7:0]  writeData_q, writeData_d;

   logic accept;
   logic sampleLow;
   logic sampleNonNeg;
   logic doWrite;
   logic [7:0] writeIdx;

   // Next-state logic: a strobe only counts toward decimation outside WAIT, and the
   // accepted sample drives the trigger/capture decision in the same cycle.
   always_comb begin
      state_d      = state_q;
      decimCnt_d   = decimCnt_q;
      timeoutCnt_d = timeoutCnt_q;
      index_d      = index_q;
      lowSeen_d    = lowSeen_q;
      readIndex_d  = readIndex_q;
      writeEn_d    = 1'b0;
      writeAddr_d  = writeAddr_q;
      writeData_d  = writeData_q;
      doWrite      = 1'b0;
      writeIdx     = index_q;

      accept       = new_sample_ready && (state_q != ST_WAIT) && (decimCnt_q == DECIM_LAST);
      sampleLow    = $signed(new_sample_in) < HYST_NEG;
      sampleNonNeg = ~new_sample_in[15];

      if (new_sample_ready && (state_q != ST_WAIT)) begin
         decimCnt_d = accept ? 8'd0 : decimCnt_q + 8'd1;
      end

      case (state_q)
         ST_ARMED: begin
            if (accept) begin
               if (sampleLow) begin
                  lowSeen_d = 1'b1;
               end
               if ((lowSeen_q && sampleNonNeg) || (timeoutCnt_q == TIMEOUT_LAST)) begin
                  doWrite  = 1'b1;
                  writeIdx = 8'd0;
                  index_d  = 8'd1;
                  state_d  = ST_ACTIVE;
               end else begin
                  timeoutCnt_d = timeoutCnt_q + 16'd1;
               end
            end
         end
         ST_ACTIVE: begin
            if (accept) begin
               doWrite = 1'b1;
               index_d = index_q + 8'd1;
               if (index_q == 8'd255) begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (wave_display_idle) begin
               readIndex_d  = ~readIndex_q;
               lowSeen_d    = 1'b0;
               timeoutCnt_d = 16'd0;
               state_d      = ST_ARMED;
            end
         end
         default: begin
            state_d = ST_ARMED;
         end
      endcase

      // Capture always targets the half the display does not own.
      if (doWrite) begin
         writeEn_d   = 1'b1;
         writeAddr_d = {~readIndex_q, writeIdx};
         writeData_d = {~new_sample_in[15], new_sample_in[14:8]};
      end
   end

   // State and registered write-port outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_ARMED;
         decimCnt_q   <= 8'd0;
         timeoutCnt_q <= 16'd0;
         index_q      <= 8'd0;
         lowSeen_q    <= 1'b0;
         readIndex_q  <= 1'b0;
         writeEn_q    <= 1'b0;
         writeAddr_q  <= 9'd0;
         writeData_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         decimCnt_q   <= decimCnt_d;
         timeoutCnt_q <= timeoutCnt_d;
         index_q      <= index_d;
         lowSeen_q    <= lowSeen_d;
         readIndex_q  <= readIndex_d;
         writeEn_q    <= writeEn_d;
         writeAddr_q  <= writeAddr_d;
         writeData_q  <= writeData_d;
      end
   end

   assign write_enable  = writeEn_q;
   assign write_address = writeAddr_q;
   assign write_sample  = writeData_q;
   assign read_index    = readIndex_q;
   assign capture_state = state_q;

endmodule

// File: tb/tb_wave_capture.sv
// Randomized and directed bench for wave_capture, compared every cycle against a
// behavioural model that tracks strobe counts, capture positions and RAM halves.
module tb_wave_capture;

   localparam int DECIM   = 3;
   localparam int HYST    = 16;
   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        new_sample_ready;
   logic [15:0] new_sample_in;
   logic        wave_display_idle;
   logic [8:0]  write_address;
   logic        write_enable;
   logic [7:0]  write_sample;
   logic        read_index;
   logic [1:0]  capture_state;

   int checks   = 0;
   int failures = 0;

   // Model state: mode 0/1/2 = armed/active/wait.
   int mState, mRead, mStrobes, mLow, mArmedAccepts, mWrites;
   int expWe, expAddr, expData;

   always #5 clk = ~clk;

   wave_capture #(.DECIM(DECIM), .HYST(HYST), .TIMEOUT(TIMEOUT)) dut (
      .clk              (clk),
      .reset            (reset),
      .new_sample_ready (new_sample_ready),
      .new_sample_in    (new_sample_in),
      .wave_display_idle(wave_display_idle),
      .write_address    (write_address),
      .write_enable     (write_enable),
      .write_sample     (write_sample),
      .read_index       (read_index),
      .capture_state    (capture_state)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic recordWrite(input int pos, input int sv);
      expWe   = 1;
      expAddr = (mRead != 0 ? 0 : 256) + pos;
      expData = (sv + 32768) >> 8;
   endtask

   // Reference behaviour: every DECIM-th strobe seen outside WAIT is a sample; the
   // capture holds 256 samples starting at the trigger.
   task automatic modelStep(input bit rst, input bit rdy, input logic [15:0] s, input bit idle);
      int sv;
      bit trig;
      sv    = int'($signed(s));
      expWe = 0;
      if (rst) begin
         mState = 0; mRead = 0; mStrobes = 0; mLow = 0; mArmedAccepts = 0; mWrites = 0;
         expAddr = 0; expData = 0;
      end else if (mState == 2) begin
         if (idle) begin
            mRead = 1 - mRead; mLow = 0; mArmedAccepts = 0; mState = 0;
         end
      end else if (rdy) begin
         mStrobes++;
         if (mStrobes % DECIM == 0) begin
            if (mState == 0) begin
               trig = (mLow != 0 && sv >= 0) || (mArmedAccepts == TIMEOUT - 1);
               if (sv < -HYST) mLow = 1;
               if (trig) begin
                  recordWrite(0, sv);
                  mWrites = 1;
                  mState  = 1;
               end else begin
                  mArmedAccepts++;
               end
            end else begin
               recordWrite(mWrites, sv);
               mWrites++;
               if (mWrites == 256) begin
                  mState  = 2;
                  mWrites = 0;
               end
            end
         end
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit rdy, input logic [15:0] s, input bit idle);
      reset             = rst;
      new_sample_ready  = rdy;
      new_sample_in     = s;
      wave_display_idle = idle;
      modelStep(rst, rdy, s, idle);
      @(posedge clk);
      #1;
      checkOutput("write_enable", write_enable, expWe);
      checkOutput("write_address", write_address, expAddr);
      checkOutput("write_sample", write_sample, expData);
      checkOutput("read_index", read_index, mRead);
      checkOutput("capture_state", capture_state, mState);
   endtask

   // Fillers are random because rejected strobes must never be evaluated.
   task automatic feedAccepted(input logic [15:0] s);
      for (int k = 0; k < DECIM - 1; k++) begin
         applyStimulus(1'b0, 1'b1, 16'($urandom), 1'b0);
         if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 1'b0, 16'($urandom), 1'b0);
      end
      applyStimulus(1'b0, 1'b1, s, 1'b0);
   endtask

   initial begin
      reset = 1'b1; new_sample_ready = 1'b0; new_sample_in = '0; wave_display_idle = 1'b0;
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h7FFF, 1'b1);
      checkOutput("reset_state", capture_state, 2'd0);
      checkOutput("reset_we", write_enable, 1'b0);
      checkOutput("reset_addr", write_address, 9'h000);

      // Basic capture
      feedAccepted(-16'sd100);
      checkOutput("basic_no_trig", write_enable, 1'b0);
      feedAccepted(16'sd50);
      checkOutput("basic_trig_we", write_enable, 1'b1);
      checkOutput("basic_trig_addr", write_address, 9'h100);
      checkOutput("basic_trig_data", write_sample, 8'h80);
      for (int i = 1; i < 256; i++) feedAccepted(16'(i * 256));
      checkOutput("basic_last_addr", write_address, 9'h1FF);
      checkOutput("basic_wait", capture_state, 2'd2);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 16'($urandom), 1'b0);

      // Swap
      for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'($urandom), 16'($urandom), 1'b0);
      checkOutput("swap_hold", read_index, 1'b0);
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1);
      checkOutput("swap_toggle", read_index, 1'b1);
      checkOutput("swap_armed", capture_state, 2'd0);

      // Hysteresis, writing into the lower half now
      feedAccepted(-16'sd10); checkOutput("hyst_a", write_enable, 1'b0);
      feedAccepted(16'sd5);   checkOutput("hyst_b", write_enable, 1'b0);
      feedAccepted(-16'sd10); checkOutput("hyst_c", write_enable, 1'b0);
      feedAccepted(16'sd5);   checkOutput("hyst_d", write_enable, 1'b0);
      feedAccepted(-16'sd17); checkOutput("hyst_e", write_enable, 1'b0);
      feedAccepted(16'sd0);
      checkOutput("hyst_trig_we", write_enable, 1'b1);
      checkOutput("hyst_trig_addr", write_address, 9'h000);
      checkOutput("hyst_trig_data", write_sample, 8'h80);
      for (int i = 1; i < 256; i++) feedAccepted(16'($urandom));
      checkOutput("lower_last_addr", write_address, 9'h0FF);
      checkOutput("lower_wait", capture_state, 2'd2);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      checkOutput("swap_back", read_index, 1'b0);

      // Timeout
      for (int k = 1; k <= TIMEOUT; k++) begin
         feedAccepted(16'sd1000);
         if (k < TIMEOUT) checkOutput("timeout_early", write_enable, 1'b0);
      end
      checkOutput("timeout_we", write_enable, 1'b1);
      checkOutput("timeout_addr", write_address, 9'h100);
      checkOutput("timeout_data", write_sample, 8'h83);
      for (int i = 1; i < 256; i++) feedAccepted(16'sd1000);
      checkOutput("timeout_wait", capture_state, 2'd2);

      // Reset mid-capture at index 100 with read_index 1
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      feedAccepted(-16'sd100);
      feedAccepted(16'sd50);
      for (int i = 0; i < 99; i++) feedAccepted(16'($urandom));
      checkOutput("mid_read_index", read_index, 1'b1);
      checkOutput("mid_addr", write_address, 9'h063);
      applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0);
      checkOutput("mid_rst_state", capture_state, 2'd0);
      checkOutput("mid_rst_read", read_index, 1'b0);
      checkOutput("mid_rst_we", write_enable, 1'b0);
      checkOutput("mid_rst_addr", write_address, 9'h000);
      checkOutput("mid_rst_data", write_sample, 8'h00);

      // Random traffic
      for (int i = 0; i < 6000; i++) begin
         applyStimulus(1'($urandom_range(0, 2999) == 0), 1'($urandom_range(0, 9) < 7),
                       16'($urandom), 1'($urandom_range(0, 19) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
